// File: rtl/store_commit_unit_pkg.sv
// Shared types for the store commit unit: store sizes, buffer entry layout, drain FSM states.
package store_commit_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } store_size_e;

    // addr is kept word-aligned; be==0 marks an entry that must not reach memory
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } stb_entry_t;

    typedef enum logic {
        STB_IDLE,
        STB_REQ
    } stb_state_e;

endpackage

// File: rtl/store_lane_gen.sv
// Converts access size and byte offset into byte enables and lane-shifted data.
// Misaligned or illegal-size accesses produce be=0 and raise misalign.
module store_lane_gen
    import store_commit_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign
);

    always_comb begin
        be       = 4'b0000;
        wdata    = 32'd0;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << off;
                wdata = {24'd0, data[7:0]} << {off, 3'b000};
            end
            SZ_HALF: begin
                if (off[0]) begin
                    misalign = 1'b1;
                end else begin
                    be    = 4'b0011 << off;
                    wdata = {16'd0, data[15:0]} << {off, 3'b000};
                end
            end
            SZ_WORD: begin
                if (off != 2'b00) begin
                    misalign = 1'b1;
                end else begin
                    be    = 4'b1111;
                    wdata = data;
                end
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_commit_unit.sv
// Store commit buffer: captures committed stores from the ROB head and drains them to memory.
// Optional macro STB_FWD_EN adds a combinational load-forwarding lookup port.
module store_commit_unit
    import store_commit_unit_pkg::*;
#(
    parameter int STB_DEPTH = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         store_valid_in,
    input  logic [31:0]                  store_addr_in,
    input  logic [31:0]                  store_data_in,
    input  logic [1:0]                   store_size_in,
    output logic                         store_read_out,
    output logic                         mem_req_out,
    output logic [ADDR_W-1:0]            mem_addr_out,
    output logic [31:0]                  mem_wdata_out,
    output logic [3:0]                   mem_be_out,
    input  logic                         mem_ack_in,
    output logic                         stb_empty_out,
    output logic [$clog2(STB_DEPTH):0]   stb_count_out,
    output logic                         misalign_err_out
`ifdef STB_FWD_EN
    ,
    input  logic [31:0]                  ld_addr_in,
    input  logic [1:0]                   ld_size_in,
    output logic                         fwd_hit_out,
    output logic [31:0]                  fwd_data_out,
    output logic                         fwd_conflict_out
`endif
);

    localparam int PTR_W = $clog2(STB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    stb_entry_t             entries [STB_DEPTH];
    logic [PTR_W-1:0]       head, tail;
    logic [CNT_W-1:0]       count;
    stb_state_e             state, state_nxt;
    stb_entry_t             head_e, load_e;
    logic                   cap, pop, load_out;
    logic [3:0]             lg_be;
    logic [31:0]            lg_wdata;
    logic                   lg_mis;

    store_lane_gen u_st_lane (
        .size     (store_size_in),
        .off      (store_addr_in[1:0]),
        .data     (store_data_in),
        .be       (lg_be),
        .wdata    (lg_wdata),
        .misalign (lg_mis)
    );

    // store_read_out gating keeps a still-visible ROB head from being captured twice
    assign cap    = store_valid_in && (count < CNT_W'(STB_DEPTH)) && !store_read_out;
    assign head_e = entries[head];
    assign load_e = (state == STB_REQ) ? entries[head + 1'b1] : head_e;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_out  = 1'b0;
        case (state)
            STB_IDLE: begin
                if (count != '0) begin
                    if (head_e.be == 4'b0000) begin
                        pop = 1'b1;
                    end else begin
                        load_out  = 1'b1;
                        state_nxt = STB_REQ;
                    end
                end
            end
            STB_REQ: begin
                if (mem_ack_in) begin
                    pop = 1'b1;
                    // a be=0 successor is retired from IDLE without touching memory
                    if (count > CNT_W'(1) && load_e.be != 4'b0000) begin
                        load_out = 1'b1;
                    end else begin
                        state_nxt = STB_IDLE;
                    end
                end
            end
            default: state_nxt = STB_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= STB_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (cap) entries[tail] <= '{addr: {store_addr_in[31:2], 2'b00}, wdata: lg_wdata, be: lg_be};
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            store_read_out   <= 1'b0;
            mem_req_out      <= 1'b0;
            mem_addr_out     <= '0;
            mem_wdata_out    <= '0;
            mem_be_out       <= '0;
            misalign_err_out <= 1'b0;
        end else begin
            store_read_out <= cap;
            if (cap) begin
                tail <= tail + 1'b1;
                if (lg_mis) misalign_err_out <= 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count       <= count + CNT_W'(cap) - CNT_W'(pop);
            mem_req_out <= (state_nxt == STB_REQ);
            if (load_out) begin
                mem_addr_out  <= load_e.addr[ADDR_W-1:0];
                mem_wdata_out <= load_e.wdata;
                mem_be_out    <= load_e.be;
            end
        end
    end

    assign stb_empty_out = (count == '0) && (state == STB_IDLE);
    assign stb_count_out = count;

`ifdef STB_FWD_EN
    logic [3:0]  ld_be;
    logic [31:0] ld_wdata;
    logic        ld_mis;
    logic [31:0] fwd_word, fwd_mask;
    stb_entry_t  fwd_e;

    store_lane_gen u_ld_lane (
        .size     (ld_size_in),
        .off      (ld_addr_in[1:0]),
        .data     (32'd0),
        .be       (ld_be),
        .wdata    (ld_wdata),
        .misalign (ld_mis)
    );

    // oldest to youngest, so the youngest overlapping entry decides the outcome
    always_comb begin
        fwd_hit_out      = 1'b0;
        fwd_conflict_out = 1'b0;
        fwd_word         = 32'd0;
        fwd_e            = '0;
        for (int i = 0; i < STB_DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                fwd_e = entries[head + PTR_W'(i)];
                if (fwd_e.addr[31:2] == ld_addr_in[31:2] && (fwd_e.be & ld_be) != 4'b0000) begin
                    if ((fwd_e.be & ld_be) == ld_be) begin
                        fwd_hit_out      = 1'b1;
                        fwd_conflict_out = 1'b0;
                        fwd_word         = fwd_e.wdata;
                    end else begin
                        fwd_hit_out      = 1'b0;
                        fwd_conflict_out = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        case (ld_size_in)
            SZ_BYTE: fwd_mask = 32'h0000_00FF;
            SZ_HALF: fwd_mask = 32'h0000_FFFF;
            default: fwd_mask = 32'hFFFF_FFFF;
        endcase
    end

    assign fwd_data_out = fwd_hit_out ? ((fwd_word >> {ld_addr_in[1:0], 3'b000}) & fwd_mask) : 32'd0;
`endif

endmodule
